// File: rtl/t00_ssdisp_pkg.sv
// t00_ssdisp_pkg: shared scan-state encoding and blank segment constant
package t00_ssdisp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, SHOW = 2'd2} state_t;
  localparam logic [7:0] SEG_OFF = 8'h00;
endpackage

// File: rtl/t00_ssdec.sv
// t00_ssdec: hex nibble to seven-segment glyph (bit 0 = a .. bit 6 = g), zero when disabled
module t00_ssdec (
  input  logic       enable,
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  logic [6:0] glyph;
  always_comb begin
    case (hex)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
  assign seg = enable ? glyph : 7'h00;
endmodule

// File: rtl/t00_ssdisp_tick.sv
// t00_ssdisp_tick: slot prescaler, counts 0..PRESCALE-1 while running and strobes guard/slot end
module t00_ssdisp_tick #(
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 16
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        run_i,
  output logic [$clog2(PRESCALE)-1:0] cnt_o,
  output logic                        guard_end_o,
  output logic                        slot_end_o
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GEND = CW'(GUARD > 0 ? GUARD - 1 : 0);
  logic [CW-1:0] cnt_q, cnt_d;
  assign slot_end_o  = cnt_q == LAST;
  assign guard_end_o = GUARD > 0 && cnt_q == GEND;
  assign cnt_d       = !run_i || slot_end_o ? '0 : cnt_q + 1'b1;
  assign cnt_o       = cnt_q;
  always_ff @(posedge clk)
    if (!nRst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/t00_ssdisp_scan.sv
// t00_ssdisp_scan: multiplexed 7-seg scan with frame-aligned shadow load; T00_SSDISP_LZB_EN enables leading-zero blanking
module t00_ssdisp_scan
  import t00_ssdisp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              enable,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   dp_mask,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam int DW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] DLAST = DW'(NDIG - 1);
  localparam logic [CW-1:0] CPEN = CW'(PRESCALE - 2);
  localparam state_t S_GUARD = t00_ssdisp_pkg::GUARD;
  localparam state_t S_ENTRY = GUARD > 0 ? S_GUARD : SHOW;
  state_t            state_q, state_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [4*NDIG-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              run, guard_end, slot_end, adv, wrap, accept, commit, blank, fd_d;
  logic [CW-1:0]     cnt;
  logic [3:0]        nib;
  logic [6:0]        dec;
  logic [7:0]        seg_d;
  logic [NDIG-1:0]   an_d;
  assign run = enable && state_q != IDLE;
  t00_ssdisp_tick #(.PRESCALE(PRESCALE), .GUARD(GUARD)) u_tick (
    .clk        (clk),
    .nRst       (nRst),
    .run_i      (run),
    .cnt_o      (cnt),
    .guard_end_o(guard_end),
    .slot_end_o (slot_end)
  );
  always_comb begin
    state_d   = !enable ? IDLE :
                state_q == IDLE ? S_ENTRY :
                state_q == S_GUARD && guard_end ? SHOW :
                state_q == SHOW && slot_end ? S_ENTRY : state_q;
    adv       = run && state_q == SHOW && slot_end;
    wrap      = adv && digit_q == DLAST;
    digit_d   = state_d == IDLE ? '0 : adv ? (wrap ? '0 : digit_q + 1'b1) : digit_q;
    accept    = load_valid && !pending_q;
    commit    = pending_q && (wrap || state_q == IDLE);
    shadow_d  = accept ? load_data : shadow_q;
    pending_d = accept || (pending_q && !commit);
    disp_d    = commit ? shadow_q : disp_q;
    fd_d      = run && digit_q == DLAST && cnt == CPEN;
  end
  // Outputs are built from next-state values so they move on the same edge as state and digit.
  assign nib = disp_d[{digit_d, 2'b00} +: 4];
`ifdef T00_SSDISP_LZB_EN
  assign blank = digit_d != '0 && (disp_d >> {digit_d, 2'b00}) == '0;
`else
  assign blank = 1'b0;
`endif
  t00_ssdec u_dec (
    .enable(1'b1),
    .hex   (nib),
    .seg   (dec)
  );
  always_comb begin
    seg_d = state_d == SHOW ? {dp_mask[digit_d], blank ? 7'd0 : dec} : SEG_OFF;
    an_d  = state_d == SHOW ? NDIG'(1) << digit_d : '0;
  end
  assign load_ready = !pending_q;
  always_ff @(posedge clk)
    if (!nRst) begin
      state_q    <= IDLE;
      digit_q    <= '0;
      disp_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= fd_d;
    end
endmodule

// File: tb/tb_t00_ssdisp_scan.sv
// tb_t00_ssdisp_scan: scoreboard bench driving GUARD=2 and GUARD=0 scanners against a frame-position model
module tb_t00_ssdisp_scan;
  localparam int N = 4;
  localparam int P = 8;
  localparam int F = N * P;
`ifdef T00_SSDISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct packed {logic [7:0] seg; logic [3:0] an; logic fd; logic rdy;} exp_t;

  logic clk = 1'b0;
  logic nRst, enable, load_valid;
  logic [15:0] load_data;
  logic [3:0] dp_mask;
  logic [7:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic fd_a, fd_b, rdy_a, rdy_b;
  int errors = 0;
  int checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit m_on [2];
  int m_t [2];
  logic [15:0] m_disp [2];
  logic [15:0] m_shadow [2];
  bit m_pend [2];

  always #5 clk = ~clk;

  t00_ssdisp_scan #(.NDIG(N), .PRESCALE(P), .GUARD(2)) dut_a (
    .clk(clk), .nRst(nRst), .enable(enable), .load_valid(load_valid), .load_ready(rdy_a),
    .load_data(load_data), .dp_mask(dp_mask), .seg(seg_a), .an(an_a), .frame_done(fd_a));
  t00_ssdisp_scan #(.NDIG(N), .PRESCALE(P), .GUARD(0)) dut_b (
    .clk(clk), .nRst(nRst), .enable(enable), .load_valid(load_valid), .load_ready(rdy_b),
    .load_data(load_data), .dp_mask(dp_mask), .seg(seg_b), .an(an_b), .frame_done(fd_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Expected outputs follow from the position t within the frame since scanning started.
  task automatic model_step(input int i);
    int g, d, w;
    bit acc, com;
    logic [15:0] hi;
    exp_t e;
    g = (i == 0) ? 2 : 0;
    if (!nRst) begin
      m_on[i] = 0; m_t[i] = 0; m_disp[i] = '0; m_shadow[i] = '0; m_pend[i] = 0;
    end else begin
      acc = load_valid && !m_pend[i];
      com = m_pend[i] && (!m_on[i] || (enable && m_t[i] == F - 1));
      if (com) m_disp[i] = m_shadow[i];
      if (acc) m_shadow[i] = load_data;
      m_pend[i] = acc || (m_pend[i] && !com);
      if (!enable) begin m_on[i] = 0; m_t[i] = 0; end
      else if (!m_on[i]) begin m_on[i] = 1; m_t[i] = 0; end
      else m_t[i] = (m_t[i] + 1) % F;
    end
    e = '0;
    e.rdy = !m_pend[i];
    if (m_on[i]) begin
      d = m_t[i] / P;
      w = m_t[i] % P;
      e.fd = m_t[i] == F - 1;
      if (w >= g) begin
        hi = m_disp[i] >> (4 * d);
        e.an = 4'(1 << d);
        e.seg = {dp_mask[d], (LZB && d > 0 && hi == 0) ? 7'd0 : GLYPH[hi[3:0]]};
      end
    end
    if (i == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic wait_pos(input int t);
    int k = 0;
    while (!(m_on[0] && m_t[0] == t) && k < 200) begin step(); k++; end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL wait_pos timeout target=%0d", t);
    end
  endtask

  task automatic load(input logic [15:0] v);
    load_valid = 1'b1; load_data = v;
    step();
    load_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("g2_seg", seg_a, e.seg); chk("g2_an", an_a, e.an);
      chk("g2_frame_done", fd_a, e.fd); chk("g2_load_ready", rdy_a, e.rdy);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("g0_seg", seg_b, e.seg); chk("g0_an", an_b, e.an);
      chk("g0_frame_done", fd_b, e.fd); chk("g0_load_ready", rdy_b, e.rdy);
    end
  end

  initial begin
    int acc;
    nRst = 1'b0;
    repeat (3) begin
      enable = 1'($urandom); load_valid = 1'($urandom);
      load_data = 16'($urandom); dp_mask = 4'($urandom);
      step();
    end
    @(negedge clk);
    chk("rst_seg", seg_a, 8'h00); chk("rst_an", an_a, 4'h0);
    chk("rst_fd", fd_a, 1'b0); chk("rst_ready", rdy_a, 1'b1);
    nRst = 1'b1; enable = 1'b0; load_valid = 1'b0; dp_mask = 4'h0;
    load(16'h1234);
    step();
    enable = 1'b1;
    wait_pos(1);
    @(negedge clk); chk("guard_blank", an_a, 4'h0); chk("g0_no_guard", an_b, 4'h1);
    wait_pos(3);
    @(negedge clk); chk("d0_an", an_a, 4'h1); chk("d0_seg", seg_a, 8'h66);
    wait_pos(10);
    @(negedge clk); chk("d1_an", an_a, 4'h2); chk("d1_seg", seg_a, 8'h4F);
    wait_pos(18);
    @(negedge clk); chk("d2_an", an_a, 4'h4); chk("d2_seg", seg_a, 8'h5B);
    wait_pos(26);
    @(negedge clk); chk("d3_an", an_a, 4'h8); chk("d3_seg", seg_a, 8'h06);
    wait_pos(31);
    @(negedge clk); chk("frame_done", fd_a, 1'b1);
    wait_pos(10);
    load(16'hABCD);
    @(negedge clk); chk("busy_after_load", rdy_a, 1'b0);
    wait_pos(18);
    @(negedge clk); chk("tearfree_d2", seg_a, 8'h5B);
    wait_pos(26);
    @(negedge clk); chk("tearfree_d3", seg_a, 8'h06);
    wait_pos(0);
    @(negedge clk); chk("ready_after_wrap", rdy_a, 1'b1);
    wait_pos(3);
    @(negedge clk); chk("new_d0", seg_a, 8'h5E);
    dp_mask = 4'b0100;
    wait_pos(18);
    @(negedge clk); chk("dp_on", seg_a[7], 1'b1);
    wait_pos(26);
    @(negedge clk); chk("dp_off", seg_a[7], 1'b0);
    wait_pos(20);
    enable = 1'b0;
    step();
    @(negedge clk); chk("dis_an", an_a, 4'h0); chk("dis_seg", seg_a, 8'h00);
    repeat (3) step();
    enable = 1'b1;
    step();
    @(negedge clk); chk("reen_guard", an_a, 4'h0);
    step(); step();
    @(negedge clk); chk("reen_d0", an_a, 4'h1);
    load(16'h0042);
    wait_pos(0);
    wait_pos(3);
    @(negedge clk); chk("lzb_d0", seg_a[6:0], 7'h5B);
    wait_pos(10);
    @(negedge clk); chk("lzb_d1", seg_a[6:0], 7'h66);
    wait_pos(26);
    @(negedge clk); chk("lzb_d3", seg_a[6:0], LZB ? 7'h00 : 7'h3F); chk("lzb_d3_an", an_a, 4'h8);
    load(16'h0000);
    wait_pos(0);
    wait_pos(3);
    @(negedge clk); chk("zero_d0", seg_a[6:0], 7'h3F);
    for (int c = 0; c < 1500; c++) begin
      nRst = $urandom_range(0, 199) != 0;
      enable = $urandom_range(0, 49) != 0;
      load_valid = $urandom_range(0, 3) == 0;
      load_data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      step();
    end
    nRst = 1'b1; enable = 1'b1; load_valid = 1'b1;
    wait_pos(0);
    wait_pos(0);
    acc = 0;
    for (int c = 0; c < 4 * F; c++) begin
      acc += int'(rdy_b);
      load_data = 16'($urandom);
      step();
    end
    chk("one_load_per_frame", acc, 4);
    load_valid = 1'b0;
    wait_pos(13);
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    @(negedge clk);
    chk("midrst_an", an_b, 4'h0); chk("midrst_ready", rdy_b, 1'b1);
    chk("midrst_seg", seg_b, 8'h00); chk("midrst_fd", fd_b, 1'b0);
    repeat (40) step();
    enable = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
